// File: rtl/vscale_mailbox_pkg.sv
// Shared constants and types for the vscale tohost/fromhost mailbox.
package vscale_mailbox_pkg;

    localparam logic [31:0] MBX_TOHOST_ADDR   = 32'h0000_1000;
    localparam logic [31:0] MBX_FROMHOST_ADDR = 32'h0000_1040;
    localparam int unsigned MBX_FIFO_DEPTH    = 4;
    localparam int unsigned TEST_CODE_W       = 31;

    typedef logic [TEST_CODE_W-1:0] test_code_t;

    // Word returned by a core load of the tohost address.
    typedef struct packed {
        logic [27:0] rsvd;
        logic [3:0]  count;
    } tohost_status_t;

    function automatic logic [31:0] status_word(input logic [3:0] count);
        tohost_status_t s;
        s.rsvd  = '0;
        s.count = count;
        return s;
    endfunction

endpackage

// File: rtl/vscale_mailbox_fifo.sv
// Synchronous FIFO with registered count/full/empty; DEPTH must be a power of two.
module vscale_mailbox_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;
    logic [CW-1:0]    count_next_c;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop_c  = pop & ~empty;
    assign do_push_c = push & (~full | do_pop_c);
    assign head      = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_next_c = count;
        if (do_push_c & ~do_pop_c) begin
            count_next_c = count + CW'(1);
        end else if (do_pop_c & ~do_push_c) begin
            count_next_c = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next_c;
            full  <= (count_next_c == CW'(DEPTH));
            empty <= (count_next_c == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vscale_tohost_mailbox.sv
// Host mailbox on the vscale dmem port: tohost FIFO, pass/fail status, fromhost word.
// Optional cycle-count timeout enabled by defining VSCALE_MAILBOX_TIMEOUT_EN.
module vscale_tohost_mailbox
    import vscale_mailbox_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = MBX_TOHOST_ADDR,
    parameter logic [31:0] FROMHOST_ADDR  = MBX_FROMHOST_ADDR,
    parameter int unsigned FIFO_DEPTH     = MBX_FIFO_DEPTH,
    parameter logic [63:0] TIMEOUT_CYCLES = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_en,
    input  logic        dmem_wen,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata_delayed,
    output logic [31:0] dmem_rdata,
    output logic        dmem_hit,
    output logic        dmem_stall,
    output logic        tohost_valid,
    input  logic        tohost_ready,
    output logic [31:0] tohost_data,
    input  logic        fromhost_valid,
    output logic        fromhost_ready,
    input  logic [31:0] fromhost_data,
    output logic        test_done,
    output logic        test_pass,
    output test_code_t  test_code,
    output logic        test_timeout
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          addr_tohost_c;
    logic          addr_fromhost_c;
    logic          hit_c;
    logic          pend_push_c;
    logic          push_c;
    logic          fh_clear_c;
    logic          fh_write_c;
    logic          dp_tohost;
    logic          dp_wen;
    logic [31:0]   fh_data;
    logic [31:0]   rdata_next_c;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    assign addr_tohost_c   = (dmem_addr == TOHOST_ADDR);
    assign addr_fromhost_c = (dmem_addr == FROMHOST_ADDR);

    // A tohost store in its data phase will occupy a slot before the next one can land.
    assign pend_push_c = dmem_hit & dp_tohost & dp_wen;
    assign dmem_stall  = dmem_en & dmem_wen & addr_tohost_c &
                         (fifo_full | (pend_push_c & (fifo_count == CW'(FIFO_DEPTH - 1))));
    assign hit_c       = dmem_en & (addr_tohost_c | addr_fromhost_c) & ~dmem_stall;

    assign push_c      = pend_push_c & (dmem_wdata_delayed != 32'd0);
    assign fh_clear_c  = dmem_hit & ~dp_tohost & dp_wen;
    assign fh_write_c  = fromhost_valid & fromhost_ready;

    vscale_mailbox_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (dmem_wdata_delayed),
        .pop       (tohost_ready),
        .head      (tohost_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tohost_valid = ~fifo_empty;

    // Load data is captured at the address phase and presented in the data phase.
    always_comb begin
        rdata_next_c = '0;
        if (hit_c & ~dmem_wen) begin
            if (addr_tohost_c) begin
                rdata_next_c = status_word(4'(fifo_count));
            end else begin
                rdata_next_c = {fh_data[31:1], fh_data[0] & ~fromhost_ready};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_hit   <= 1'b0;
            dp_tohost  <= 1'b0;
            dp_wen     <= 1'b0;
            dmem_rdata <= '0;
        end else begin
            dmem_hit   <= hit_c;
            dp_tohost  <= addr_tohost_c;
            dp_wen     <= dmem_wen;
            dmem_rdata <= rdata_next_c;
        end
    end

    // Fromhost register; a harness write beats a simultaneous core clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            fromhost_ready <= 1'b1;
            fh_data        <= '0;
        end else if (fh_write_c) begin
            fromhost_ready <= 1'b0;
            fh_data        <= fromhost_data;
        end else if (fh_clear_c) begin
            fromhost_ready <= 1'b1;
        end
    end

`ifdef VSCALE_MAILBOX_TIMEOUT_EN
    logic [63:0] cycle_count;
    logic [63:0] cycle_next_c;
    logic        timeout_hit_c;

    // Compare the count this edge produces so the flag lands on cycle TIMEOUT_CYCLES+1.
    assign cycle_next_c  = cycle_count + 64'd1;
    assign timeout_hit_c = (TIMEOUT_CYCLES != 64'd0) && (cycle_next_c > TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count  <= '0;
            test_timeout <= 1'b0;
        end else begin
            cycle_count <= cycle_next_c;
            if (~test_done & ~push_c & timeout_hit_c) test_timeout <= 1'b1;
        end
    end
`else
    assign test_timeout = 1'b0 & (|TIMEOUT_CYCLES);
`endif

    // First nonzero tohost value (or a timeout) decides the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            test_done <= 1'b0;
            test_pass <= 1'b0;
            test_code <= '0;
        end else if (~test_done) begin
            if (push_c) begin
                test_done <= 1'b1;
                test_pass <= (dmem_wdata_delayed == 32'd1);
                test_code <= test_code_t'(dmem_wdata_delayed[31:1]);
            end
`ifdef VSCALE_MAILBOX_TIMEOUT_EN
            else if (timeout_hit_c) begin
                test_done <= 1'b1;
                test_pass <= 1'b0;
                test_code <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_vscale_tohost_mailbox.sv
// Directed self-checking bench for vscale_tohost_mailbox.
module tb_vscale_tohost_mailbox;

    localparam logic [31:0] TOHOST   = 32'h0000_1000;
    localparam logic [31:0] FROMHOST = 32'h0000_1040;
`ifdef VSCALE_MAILBOX_TIMEOUT_EN
    localparam logic [63:0] TB_TIMEOUT = 64'd100;
`else
    localparam logic [63:0] TB_TIMEOUT = 64'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        dmem_en;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata_delayed;
    logic [31:0] dmem_rdata;
    logic        dmem_hit;
    logic        dmem_stall;
    logic        tohost_valid;
    logic        tohost_ready;
    logic [31:0] tohost_data;
    logic        fromhost_valid;
    logic        fromhost_ready;
    logic [31:0] fromhost_data;
    logic        test_done;
    logic        test_pass;
    logic [30:0] test_code;
    logic        test_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vscale_tohost_mailbox #(
        .TOHOST_ADDR    (TOHOST),
        .FROMHOST_ADDR  (FROMHOST),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .dmem_en            (dmem_en),
        .dmem_wen           (dmem_wen),
        .dmem_addr          (dmem_addr),
        .dmem_wdata_delayed (dmem_wdata_delayed),
        .dmem_rdata         (dmem_rdata),
        .dmem_hit           (dmem_hit),
        .dmem_stall         (dmem_stall),
        .tohost_valid       (tohost_valid),
        .tohost_ready       (tohost_ready),
        .tohost_data        (tohost_data),
        .fromhost_valid     (fromhost_valid),
        .fromhost_ready     (fromhost_ready),
        .fromhost_data      (fromhost_data),
        .test_done          (test_done),
        .test_pass          (test_pass),
        .test_code          (test_code),
        .test_timeout       (test_timeout)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        dmem_en            = 1'b0;
        dmem_wen           = 1'b0;
        dmem_addr          = '0;
        dmem_wdata_delayed = '0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        tohost_ready   = 1'b0;
        fromhost_valid = 1'b0;
        fromhost_data  = '0;
        bus_idle();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Address phase, then data phase; returns just after the data-phase edge.
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = addr;
        cyc();
        dmem_en = 1'b0; dmem_wen = 1'b0; dmem_wdata_delayed = data;
        cyc();
        dmem_wdata_delayed = '0;
    endtask

    // Returns inside the data phase, with dmem_rdata valid.
    task automatic load(input logic [31:0] addr);
        dmem_en = 1'b1; dmem_wen = 1'b0; dmem_addr = addr;
        cyc();
        dmem_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dmem_hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%b exp=0", dmem_hit); end
        checks++; if (dmem_rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", dmem_rdata); end
        checks++; if (tohost_valid !== 1'b0) begin failures++; $display("FAIL rst_tohost_valid got=%b exp=0", tohost_valid); end
        checks++; if (fromhost_ready !== 1'b1) begin failures++; $display("FAIL rst_fromhost_ready got=%b exp=1", fromhost_ready); end
        checks++; if ({test_done, test_pass, test_timeout} !== 3'b000) begin failures++; $display("FAIL rst_status got=%b exp=000", {test_done, test_pass, test_timeout}); end
        checks++; if (test_code !== 31'd0) begin failures++; $display("FAIL rst_code got=%h exp=0", test_code); end
        checks++; if (dmem_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", dmem_stall); end
    endtask

    task automatic test_pass_store();
        do_reset();
        tohost_ready = 1'b1;
        dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = TOHOST;
        cyc();
        checks++; if (dmem_hit !== 1'b1) begin failures++; $display("FAIL pass_hit got=%b exp=1", dmem_hit); end
        dmem_en = 1'b0; dmem_wen = 1'b0; dmem_wdata_delayed = 32'd1;
        cyc();
        dmem_wdata_delayed = '0;
        checks++; if (tohost_valid !== 1'b1) begin failures++; $display("FAIL pass_valid got=%b exp=1", tohost_valid); end
        checks++; if (tohost_data !== 32'd1) begin failures++; $display("FAIL pass_data got=%h exp=1", tohost_data); end
        checks++; if ({test_done, test_pass} !== 2'b11) begin failures++; $display("FAIL pass_status got=%b exp=11", {test_done, test_pass}); end
        checks++; if (test_code !== 31'd0) begin failures++; $display("FAIL pass_code got=%h exp=0", test_code); end
        cyc();
        checks++; if (tohost_valid !== 1'b0) begin failures++; $display("FAIL pass_drained got=%b exp=0", tohost_valid); end
    endtask

    task automatic test_first_wins();
        do_reset();
        tohost_ready = 1'b1;
        store(TOHOST, 32'd7);
        checks++; if (tohost_data !== 32'd7) begin failures++; $display("FAIL fw_data7 got=%h exp=7", tohost_data); end
        checks++; if ({test_done, test_pass} !== 2'b10) begin failures++; $display("FAIL fw_status got=%b exp=10", {test_done, test_pass}); end
        checks++; if (test_code !== 31'd3) begin failures++; $display("FAIL fw_code got=%h exp=3", test_code); end
        cyc();
        store(TOHOST, 32'd1);
        checks++; if (tohost_data !== 32'd1) begin failures++; $display("FAIL fw_data1 got=%h exp=1", tohost_data); end
        checks++; if ({test_done, test_pass} !== 2'b10) begin failures++; $display("FAIL fw_status2 got=%b exp=10", {test_done, test_pass}); end
        checks++; if (test_code !== 31'd3) begin failures++; $display("FAIL fw_code2 got=%h exp=3", test_code); end
        cyc();
        checks++; if (tohost_valid !== 1'b0) begin failures++; $display("FAIL fw_drained got=%b exp=0", tohost_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [5];
        logic        exp_stall;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44; vals[4] = 32'h55;
        do_reset();
        tohost_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = TOHOST;
            dmem_wdata_delayed = (i == 0) ? 32'd0 : vals[i-1];
            #1;
            exp_stall = (i == 4);
            checks++; if (dmem_stall !== exp_stall) begin failures++; $display("FAIL b2b_stall[%0d] got=%b exp=%b", i, dmem_stall, exp_stall); end
            if (i < 4) cyc();
        end
        cyc();
        dmem_wdata_delayed = '0;
        #1;
        checks++; if (dmem_hit !== 1'b0) begin failures++; $display("FAIL b2b_stalled_hit got=%b exp=0", dmem_hit); end
        checks++; if (dmem_stall !== 1'b1) begin failures++; $display("FAIL b2b_full_stall got=%b exp=1", dmem_stall); end
        checks++; if (tohost_data !== vals[0]) begin failures++; $display("FAIL b2b_head got=%h exp=%h", tohost_data, vals[0]); end
        tohost_ready = 1'b1;
        cyc();
        tohost_ready = 1'b0;
        #1;
        checks++; if (dmem_stall !== 1'b0) begin failures++; $display("FAIL b2b_release got=%b exp=0", dmem_stall); end
        cyc();
        checks++; if (dmem_hit !== 1'b1) begin failures++; $display("FAIL b2b_fifth_hit got=%b exp=1", dmem_hit); end
        dmem_en = 1'b0; dmem_wen = 1'b0; dmem_wdata_delayed = vals[4];
        cyc();
        dmem_wdata_delayed = '0;
        load(TOHOST);
        checks++; if (dmem_rdata !== 32'd4) begin failures++; $display("FAIL b2b_count got=%h exp=4", dmem_rdata); end
        tohost_ready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            checks++; if (tohost_data !== vals[j]) begin failures++; $display("FAIL b2b_order[%0d] got=%h exp=%h", j, tohost_data, vals[j]); end
            cyc();
        end
        checks++; if (tohost_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", tohost_valid); end
    endtask

    task automatic test_zero_store();
        do_reset();
        tohost_ready = 1'b0;
        store(TOHOST, 32'd0);
        checks++; if (tohost_valid !== 1'b0) begin failures++; $display("FAIL zero_valid got=%b exp=0", tohost_valid); end
        checks++; if (test_done !== 1'b0) begin failures++; $display("FAIL zero_done got=%b exp=0", test_done); end
        load(TOHOST);
        checks++; if (dmem_hit !== 1'b1) begin failures++; $display("FAIL zero_load_hit got=%b exp=1", dmem_hit); end
        checks++; if (dmem_rdata !== 32'd0) begin failures++; $display("FAIL zero_count got=%h exp=0", dmem_rdata); end
        store(TOHOST, 32'd5);
        load(TOHOST);
        checks++; if (dmem_rdata !== 32'd1) begin failures++; $display("FAIL zero_count1 got=%h exp=1", dmem_rdata); end
        checks++; if (test_code !== 31'd2) begin failures++; $display("FAIL zero_code5 got=%h exp=2", test_code); end
        cyc();
        checks++; if (dmem_rdata !== 32'd0) begin failures++; $display("FAIL idle_rdata got=%h exp=0", dmem_rdata); end
    endtask

    task automatic test_fromhost();
        do_reset();
        fromhost_valid = 1'b1; fromhost_data = 32'h1357_9BDF;
        cyc();
        fromhost_valid = 1'b0;
        checks++; if (fromhost_ready !== 1'b0) begin failures++; $display("FAIL fh_ready_full got=%b exp=0", fromhost_ready); end
        load(FROMHOST);
        checks++; if (dmem_rdata !== 32'h1357_9BDF) begin failures++; $display("FAIL fh_load_full got=%h exp=13579bdf", dmem_rdata); end
        cyc();
        store(FROMHOST, 32'hDEAD_BEEF);
        checks++; if (fromhost_ready !== 1'b1) begin failures++; $display("FAIL fh_cleared got=%b exp=1", fromhost_ready); end
        load(FROMHOST);
        checks++; if (dmem_rdata !== 32'h1357_9BDE) begin failures++; $display("FAIL fh_load_empty got=%h exp=13579bde", dmem_rdata); end
        cyc();
        fromhost_valid = 1'b1; fromhost_data = 32'hABCD_0002;
        cyc();
        checks++; if (fromhost_ready !== 1'b0) begin failures++; $display("FAIL fh_ready_abcd got=%b exp=0", fromhost_ready); end
        fromhost_data = 32'h9999_9999;
        cyc();
        fromhost_valid = 1'b0;
        load(FROMHOST);
        checks++; if (dmem_rdata !== 32'hABCD_0002) begin failures++; $display("FAIL fh_load_abcd got=%h exp=abcd0002", dmem_rdata); end
        cyc();
        store(FROMHOST, 32'd0);
        dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = FROMHOST;
        cyc();
        dmem_en = 1'b0; dmem_wen = 1'b0;
        fromhost_valid = 1'b1; fromhost_data = 32'h2468_ACE1;
        cyc();
        fromhost_valid = 1'b0;
        checks++; if (fromhost_ready !== 1'b0) begin failures++; $display("FAIL fh_race_ready got=%b exp=0", fromhost_ready); end
        load(FROMHOST);
        checks++; if (dmem_rdata !== 32'h2468_ACE1) begin failures++; $display("FAIL fh_race_data got=%h exp=2468ace1", dmem_rdata); end
        cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        tohost_ready = 1'b0;
        store(TOHOST, 32'd3);
        store(TOHOST, 32'd9);
        fromhost_valid = 1'b1; fromhost_data = 32'hFFFF_FFFF;
        dmem_en = 1'b1; dmem_wen = 1'b1; dmem_addr = TOHOST;
        cyc();
        fromhost_valid = 1'b0;
        dmem_en = 1'b0; dmem_wen = 1'b0; dmem_wdata_delayed = 32'h77;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        dmem_wdata_delayed = '0;
        checks++; if (tohost_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", tohost_valid); end
        checks++; if (tohost_data !== 32'd0) begin failures++; $display("FAIL mid_data got=%h exp=0", tohost_data); end
        checks++; if ({dmem_hit, test_done, test_pass} !== 3'b000) begin failures++; $display("FAIL mid_flags got=%b exp=000", {dmem_hit, test_done, test_pass}); end
        checks++; if (test_code !== 31'd0) begin failures++; $display("FAIL mid_code got=%h exp=0", test_code); end
        checks++; if (fromhost_ready !== 1'b1) begin failures++; $display("FAIL mid_fh_ready got=%b exp=1", fromhost_ready); end
        cyc();
        checks++; if (tohost_valid !== 1'b0) begin failures++; $display("FAIL mid_discard got=%b exp=0", tohost_valid); end
    endtask

    task automatic test_timeout_feature();
        do_reset();
        for (int i = 0; i < 100; i++) cyc();
`ifdef VSCALE_MAILBOX_TIMEOUT_EN
        checks++; if (test_timeout !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", test_timeout); end
        cyc();
        checks++; if ({test_done, test_timeout, test_pass} !== 3'b110) begin failures++; $display("FAIL to_fire got=%b exp=110", {test_done, test_timeout, test_pass}); end
        checks++; if (test_code !== 31'd0) begin failures++; $display("FAIL to_code got=%h exp=0", test_code); end
`else
        for (int i = 0; i < 20; i++) cyc();
        checks++; if ({test_done, test_timeout} !== 2'b00) begin failures++; $display("FAIL to_off got=%b exp=00", {test_done, test_timeout}); end
`endif
    endtask

    initial begin
        test_reset();
        test_pass_store();
        test_first_wins();
        test_back_to_back();
        test_zero_store();
        test_fromhost();
        test_reset_mid();
        test_timeout_feature();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vscale_tohost_mailbox.md
Name: vscale_tohost_mailbox

Overview:
- Memory-mapped host mailbox on the vscale dmem port.
- Captures core stores to TOHOST_ADDR into a small FIFO and drains them to the simulation harness over a valid/ready channel.
- Decodes pass/fail into sticky status outputs.
- Holds one fromhost word, written by the harness and read and acknowledged by the core.

Parameters:
- TOHOST_ADDR, 32'h00001000, byte address of tohost word
- FROMHOST_ADDR, 32'h00001040, byte address of fromhost word
- FIFO_DEPTH, 4, tohost FIFO entries; power of two, at least 2
- TIMEOUT_CYCLES, 64'd0, timeout limit; 0 disables; used only with the optional feature

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- dmem_en  in  1  core address phase valid
- dmem_wen  in  1  address phase is a store
- dmem_addr  in  32  address phase address
- dmem_wdata_delayed  in  32  store data, valid one cycle after its address phase
- dmem_rdata  out  32  load data, valid one cycle after its address phase
- dmem_hit  out  1  registered; the current data phase belongs to this block (system muxes rdata on it)
- dmem_stall  out  1  combinational; core must hold its address phase
- tohost_valid  out  1  FIFO head valid
- tohost_ready  in  1  harness accepts head
- tohost_data  out  32  FIFO head
- fromhost_valid  in  1  harness offers fromhost word
- fromhost_ready  out  1  fromhost register empty
- fromhost_data  in  32  harness word
- test_done  out  1  sticky: nonzero tohost seen, or timeout
- test_pass  out  1  sticky: the first nonzero tohost value was 1
- test_code  out  31  data>>1 of the first nonzero tohost value
- test_timeout  out  1  sticky timeout flag; tied 0 without the optional feature

Behaviour:
- Reset (synchronous, clk edge with reset=1): FIFO empty, pending write cleared, fromhost empty with data 0, dmem_hit=0, dmem_rdata=0, all test_* = 0, cycle counter = 0. Reset in the middle of a transaction discards the pending data phase.
- Address phase hit: dmem_en=1 and dmem_addr equals TOHOST_ADDR or FROMHOST_ADDR (full 32-bit compare). On an unstalled hit, the next cycle is a data phase with dmem_hit=1.
- Tohost store stall: dmem_stall=1 when dmem_en & dmem_wen & addr==TOHOST_ADDR & (count + pend_push) >= FIFO_DEPTH. pend_push is 1 when the current cycle is a tohost data phase. A stalled address phase is not registered.
- Tohost data phase: nonzero dmem_wdata_delayed is pushed. Zero is dropped and affects neither the FIFO nor status.
- Status on push: if test_done=0, set test_done=1, test_pass=(data==1), test_code=data[31:1]. Later pushes do not alter status; first result wins.
- Drain: tohost_valid = count!=0. A pop occurs when tohost_valid & tohost_ready. Push and pop in the same cycle leave count unchanged and are legal when full. Pointers wrap modulo FIFO_DEPTH.
- Fromhost, harness side: fromhost_ready = !fh_full. When fromhost_valid & fromhost_ready, latch data and set fh_full.
- Fromhost, core store to FROMHOST_ADDR: clears fh_full in the data phase; store data is ignored.
- Simultaneous harness write and core clear: the harness write wins. New data is latched and fh_full stays 1.
- Loads: FROMHOST_ADDR returns the fromhost register in the data phase, with bit 0 forced to 0 when fh_full=0. TOHOST_ADDR returns {28'b0, count[3:0]}. dmem_rdata is 0 whenever dmem_hit=0.
- Latency: store address phase to tohost_valid is 2 cycles when the FIFO is empty.

Optional Feature:
- Macro: VSCALE_MAILBOX_TIMEOUT_EN.
- Enabled: a 64-bit cycle counter increments every non-reset cycle. When TIMEOUT_CYCLES!=0 and the counter exceeds TIMEOUT_CYCLES while test_done=0, set test_done=1, test_timeout=1, test_pass=0, test_code=0, all sticky.
- Disabled: no counter; test_timeout tied 0; TIMEOUT_CYCLES unused.

Decomposition:
- Package vscale_mailbox_pkg: address constants, the 31-bit test-code type, and the status-read field layout.
- One sub-module, vscale_mailbox_fifo, parameterised by depth and width, with push, pop, count, full and empty.
- Address decode, stall, fromhost register and status logic stay in the top module.

Test Plan:
- Store 32'h1 to 0x1000, tohost_ready=1: tohost_data=1 two cycles after the address phase; then test_done=1, test_pass=1, test_code=0.
- Store 32'h7 then 32'h1: test_pass=0, test_code=3; the second store pops but status is unchanged.
- tohost_ready=0, five back-to-back stores of nonzero values: first four accepted, fifth stalled. Raise ready for one cycle: the stall releases next cycle and FIFO order is preserved.
- Store 0 to 0x1000: no push, test_done stays 0, count load returns 0.
- Harness writes 32'hABCD0002: fromhost_ready drops; a core load of 0x1040 returns 32'hABCD0002. A core store to 0x1040 in the same cycle as a new harness write leaves fh_full=1 holding the new data.
- With VSCALE_MAILBOX_TIMEOUT_EN and TIMEOUT_CYCLES=100, no stores: test_timeout=1 and test_done=1 on cycle 101. Assert reset mid-FIFO: all outputs return to 0 the next cycle.
